// File: rtl/eval_arbiter.sv
// Round-robin arbiter that shares one bitwise evaluation unit among N_REQ requesters.
// Each accepted request runs GRANT -> EVAL -> DONE and produces c = a & b, d = a | (b ^ c).
module eval_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic               valid_out,
    output logic [W-1:0]       c_out,
    output logic [W-1:0]       d_out,
    output logic [IW-1:0]      id_out
);

    // state | meaning
    // IDLE  | waiting for any req; winner chosen from ptr on the way out
    // GRANT | gnt[win] high, winner's operands latched at the end of the cycle
    // EVAL  | results registered at the end of the cycle
    // DONE  | valid_out high, ptr advances past the winner at the end of the cycle
    typedef enum logic [1:0] {IDLE, GRANT, EVAL, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] win_nx;
    logic [IW:0]   cand;
    logic          found;
    logic [W-1:0]  a_lat;
    logic [W-1:0]  b_lat;
    logic [W-1:0]  c_nx;

    always_comb begin
        found  = 1'b0;
        win_nx = ptr;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ))
                cand = cand - (IW+1)'(N_REQ);
            if (!found && req[cand[IW-1:0]]) begin
                found  = 1'b1;
                win_nx = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        gnt       = '0;
        busy      = 1'b1;
        valid_out = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (|req)
                    state_nx = GRANT;
            end
            GRANT: begin
                gnt[win] = 1'b1;
                state_nx = EVAL;
            end
            EVAL:  state_nx = DONE;
            DONE: begin
                valid_out = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign c_nx = a_lat & b_lat;

    // Results are registered on the EVAL->DONE edge so they are already valid
    // during the DONE cycle that carries the valid_out pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= '0;
            win    <= '0;
            a_lat  <= '0;
            b_lat  <= '0;
            c_out  <= '0;
            d_out  <= '0;
            id_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req)
                        win <= win_nx;
                end
                GRANT: begin
                    a_lat <= a_in[win*W +: W];
                    b_lat <= b_in[win*W +: W];
                end
                EVAL: begin
                    c_out  <= c_nx;
                    d_out  <= a_lat | (b_lat ^ c_nx);
                    id_out <= win;
                end
                DONE: begin
                    ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
